// File: rtl/sqwave_gen.sv
// sqwave_gen: burst square-wave generator with a real-valued analog output.
// A valid start latches half_period/num_toggles/amplitude and emits
// num_toggles level transitions, each level held half_period cycles.
// Ports: clk, rst_n (async, active-low), start, abort, half_period,
//   num_toggles, amplitude (real) -> a_out (real), rise_evt, fall_evt,
//   busy, done.
// Optional macro SQWAVE_SLEW_EN: linear ramps of SLEW_STEPS cycles per edge.
module sqwave_gen #(
    parameter int HP_W       = 16,
    parameter int CNT_W      = 8,
    parameter int SLEW_STEPS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [HP_W-1:0]  half_period,
    input  logic [CNT_W-1:0] num_toggles,
    input  real              amplitude,
    output real              a_out,
    output logic             rise_evt,
    output logic             fall_evt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

`ifdef SQWAVE_SLEW_EN
    // A ramp must finish before the next edge is due.
    localparam logic [HP_W-1:0] MinHp = HP_W'(SLEW_STEPS);
    localparam int RampW = $clog2(SLEW_STEPS + 1);
`else
    // Instantaneous edges: any nonzero half period is valid.
    localparam logic [HP_W-1:0] MinHp = HP_W'((SLEW_STEPS * 0) + 1);
`endif

    state_t           state_q, state_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [CNT_W-1:0] n_q, n_d;
    real              amp_q, amp_d;
    logic [HP_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             lvl_q, lvl_d;
    real              a_q, a_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SQWAVE_SLEW_EN
    logic [RampW-1:0] ramp_q, ramp_d;
`endif

    logic req;
    logic valid;
    logic wrap;
    logic last;

    // abort takes priority over a coincident start in IDLE
    assign req   = start && !abort;
    assign valid = (half_period >= MinHp) && (num_toggles != '0);
    assign wrap  = (hcnt_q == hp_q - HP_W'(1));
    assign last  = wrap && (tcnt_q == n_q);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = valid ? RUN : FINISH;
            end
            RUN: begin
                if (abort)     state_d = IDLE;
                else if (last) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath / registered-output next values
    always_comb begin
        hp_d   = hp_q;
        n_d    = n_q;
        amp_d  = amp_q;
        hcnt_d = hcnt_q;
        tcnt_d = tcnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
`ifdef SQWAVE_SLEW_EN
        ramp_d = (ramp_q < RampW'(SLEW_STEPS)) ? ramp_q + RampW'(1) : ramp_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    hp_d   = half_period;
                    n_d    = num_toggles;
                    amp_d  = amplitude;
                    hcnt_d = '0;
                    if (valid) begin
                        tcnt_d = CNT_W'(1);
                        lvl_d  = 1'b1;
                        rise_d = 1'b1;
                        busy_d = 1'b1;
`ifdef SQWAVE_SLEW_EN
                        ramp_d = RampW'(1);
`endif
                    end else begin
                        tcnt_d = '0;
                        lvl_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    fall_d = lvl_q;
                    lvl_d  = 1'b0;
                    hcnt_d = '0;
                    tcnt_d = '0;
                end else if (last) begin
                    fall_d = lvl_q;
                    lvl_d  = 1'b0;
                    done_d = 1'b1;
                    hcnt_d = '0;
                end else if (wrap) begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                    lvl_d  = !lvl_q;
                    rise_d = !lvl_q;
                    fall_d = lvl_q;
                    busy_d = 1'b1;
                    hcnt_d = '0;
`ifdef SQWAVE_SLEW_EN
                    ramp_d = RampW'(1);
`endif
                end else begin
                    hcnt_d = hcnt_q + HP_W'(1);
                    busy_d = 1'b1;
                end
            end
            FINISH: begin
                hcnt_d = '0;
                tcnt_d = '0;
                lvl_d  = 1'b0;
            end
            default: begin
                lvl_d = 1'b0;
            end
        endcase
    end

    // analog level: zero whenever no burst is running
    always_comb begin
        a_d = 0.0;
`ifdef SQWAVE_SLEW_EN
        if (busy_d) begin
            if (lvl_d)
                a_d = amp_d * real'(ramp_d) / real'(SLEW_STEPS);
            else
                a_d = amp_d * real'(SLEW_STEPS - int'(ramp_d)) / real'(SLEW_STEPS);
        end
`else
        if (busy_d && lvl_d) a_d = amp_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q   <= '0;
            n_q    <= '0;
            amp_q  <= 0.0;
            hcnt_q <= '0;
            tcnt_q <= '0;
            lvl_q  <= 1'b0;
            a_q    <= 0.0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SQWAVE_SLEW_EN
            ramp_q <= '0;
`endif
        end else begin
            hp_q   <= hp_d;
            n_q    <= n_d;
            amp_q  <= amp_d;
            hcnt_q <= hcnt_d;
            tcnt_q <= tcnt_d;
            lvl_q  <= lvl_d;
            a_q    <= a_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef SQWAVE_SLEW_EN
            ramp_q <= ramp_d;
`endif
        end
    end

    assign a_out    = a_q;
    assign rise_evt = rise_q;
    assign fall_evt = fall_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sqwave_gen.sv
// tb_sqwave_gen: directed self-checking bench for sqwave_gen.
// Cycle 0 is the cycle start is presented; checks sample #1 after edges.
module tb_sqwave_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] hp;
    logic [7:0]  nt;
    real         amp;
    real         a_out;
    logic        rise_evt;
    logic        fall_evt;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sqwave_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .half_period (hp),
        .num_toggles (nt),
        .amplitude   (amp),
        .a_out       (a_out),
        .rise_evt    (rise_evt),
        .fall_evt    (fall_evt),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input real got, input real exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%g exp=%g", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a start for one cycle; returns in cycle 1
    task automatic go(input int h, input int n, input real a);
        hp    = 16'(h);
        nt    = 8'(n);
        amp   = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        real exp_a [8];
        int  exp_r, exp_f, exp_b, exp_d;
        int  rises, falls, both, done_c, last_r, last_f;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        hp    = '0;
        nt    = '0;
        amp   = 0.0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst a_out", a_out, 0.0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst rise", rise_evt, 0);
        chk("rst fall", fall_evt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifdef SQWAVE_SLEW_EN
        go(8, 1, 1.0);
        for (int c = 1; c <= 9; c++) begin
            if (c <= 4) chk($sformatf("slew a c%0d", c), a_out, 0.25 * c);
            if (c == 5) chk("slew hold", a_out, 1.0);
            if (c == 9) begin
                chk("slew fin a", a_out, 0.0);
                chk("slew fin done", done, 1);
                chk("slew fin fall", fall_evt, 1);
            end
            tick();
        end
        go(3, 2, 1.0);
        chk("slew inv done", done, 1);
        chk("slew inv busy", busy, 0);
        chk("slew inv rise", rise_evt, 0);
        tick();
`else
        // HP=2 N=3 amp=0.5; inputs changed after cycle 0 must not matter
        exp_a = '{0.5, 0.5, 0.0, 0.0, 0.5, 0.5, 0.0, 0.0};
        exp_r = 'b00010001;
        exp_f = 'b01000100;
        exp_b = 'b00111111;
        exp_d = 'b01000000;
        go(2, 3, 0.5);
        amp = 9.0;
        hp  = 16'd7;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("p3 a c%0d", c), a_out, exp_a[c-1]);
            chk($sformatf("p3 rise c%0d", c), rise_evt, exp_r[c-1]);
            chk($sformatf("p3 fall c%0d", c), fall_evt, exp_f[c-1]);
            chk($sformatf("p3 busy c%0d", c), busy, exp_b[c-1]);
            chk($sformatf("p3 done c%0d", c), done, exp_d[c-1]);
            if (c < 8) tick();
        end
        tick();

        // HP=10 N=20 amp=1.0 with an ignored start while busy
        rises  = 0;
        falls  = 0;
        both   = 0;
        done_c = 0;
        last_r = 0;
        last_f = 0;
        go(10, 20, 1.0);
        for (int c = 1; c <= 202; c++) begin
            if (rise_evt) begin
                rises++;
                last_r = c;
            end
            if (fall_evt) begin
                falls++;
                last_f = c;
            end
            if (rise_evt && fall_evt) both++;
            if (done && done_c == 0) done_c = c;
            if (c == 202) begin
                chk("p2 after a", a_out, 0.0);
                chk("p2 after busy", busy, 0);
            end
            if (c == 50) begin
                hp    = 16'd1;
                nt    = 8'd1;
                amp   = 5.0;
                start = 1'b1;
            end
            if (c == 51) start = 1'b0;
            if (c < 202) tick();
        end
        chk("p2 rises", rises, 10);
        chk("p2 falls", falls, 10);
        chk("p2 both", both, 0);
        chk("p2 done cyc", done_c, 201);
        chk("p2 last rise", last_r, 181);
        chk("p2 last fall", last_f, 191);
        tick();

        // HP=4 N=8 amp=-2.0, abort at cycle 6, restart at cycle 9
        go(4, 8, -2.0);
        chk("p4 a c1", a_out, -2.0);
        repeat (4) tick();
        chk("p4 a c5", a_out, 0.0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("p4 a c7", a_out, 0.0);
        chk("p4 busy c7", busy, 0);
        chk("p4 done c7", done, 0);
        chk("p4 fall c7", fall_evt, 0);
        tick();
        chk("p4 done c8", done, 0);
        tick();
        go(1, 2, 3.0);
        chk("p4 re a", a_out, 3.0);
        chk("p4 re rise", rise_evt, 1);
        tick();
        chk("p4 re a2", a_out, 0.0);
        chk("p4 re fall", fall_evt, 1);
        chk("p4 re busy", busy, 1);
        tick();
        chk("p4 re done", done, 1);
        chk("p4 re fin fall", fall_evt, 0);
        chk("p4 re fin busy", busy, 0);
        tick();

        // abort while the level is high
        go(5, 4, 1.0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab hi fall", fall_evt, 1);
        chk("ab hi a", a_out, 0.0);
        chk("ab hi done", done, 0);
        tick();

        // abort and start together in IDLE
        hp    = 16'd2;
        nt    = 8'd2;
        amp   = 1.0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("ab+st busy", busy, 0);
        chk("ab+st rise", rise_evt, 0);
        chk("ab+st done", done, 0);
        tick();

        // invalid starts; a start in FINISH is ignored
        go(5, 0, 1.0);
        chk("inv n0 done", done, 1);
        chk("inv n0 busy", busy, 0);
        chk("inv n0 rise", rise_evt, 0);
        chk("inv n0 a", a_out, 0.0);
        tick();
        chk("inv n0 done2", done, 0);
        go(0, 3, 1.0);
        chk("inv h0 done", done, 1);
        chk("inv h0 rise", rise_evt, 0);
        hp    = 16'd2;
        nt    = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fin st busy", busy, 0);
        chk("fin st rise", rise_evt, 0);
        tick();

        // async reset mid-burst, then start on first edge after release
        go(3, 5, 1.0);
        repeat (4) tick();
        chk("rs busy c5", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rs a", a_out, 0.0);
        chk("rs busy", busy, 0);
        chk("rs rise", rise_evt, 0);
        chk("rs fall", fall_evt, 0);
        tick();
        tick();
        chk("rs done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        go(2, 1, 0.5);
        chk("rs re busy", busy, 1);
        chk("rs re rise", rise_evt, 1);
        chk("rs re a", a_out, 0.5);
        tick();
        tick();
        chk("rs re done", done, 1);
        chk("rs re fall", fall_evt, 1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sqwave_gen.md
SQWAVE_GEN -- requirements
Module: sqwave_gen

Interface
REQ-001 Parameter HP_W, 16, width of half_period.
REQ-002 Parameter CNT_W, 8, width of num_toggles and the toggle counter.
REQ-003 Parameter SLEW_STEPS, 4, number of ramp steps per transition (used only with SQWAVE_SLEW_EN).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request a burst; sampled only in IDLE.
REQ-007 abort  input  1  synchronous burst cancel.
REQ-008 half_period  input  HP_W  clock cycles each level is held.
REQ-009 num_toggles  input  CNT_W  total level transitions in the burst, counting the first rise.
REQ-010 amplitude  input  real  high level, any sign.
REQ-011 a_out  output  real (wreal)  generated analog level.
REQ-012 rise_evt  output  1  one-cycle pulse in the cycle a_out leaves 0.0 toward amplitude.
REQ-013 fall_evt  output  1  one-cycle pulse in the cycle a_out leaves amplitude toward 0.0.
REQ-014 busy  output  1  burst in progress.
REQ-015 done  output  1  one-cycle pulse at normal burst completion.

Function
REQ-016 States: IDLE, RUN, FINISH; IDLE holds a_out=0.0, busy=0.
REQ-017 Valid start: start=1 in IDLE with half_period>=1 and num_toggles>=1; half_period, num_toggles and amplitude are latched in that cycle (cycle 0); later input changes have no effect on the burst.
REQ-018 Cycle 1 after a valid start: state RUN, busy=1, a_out=amplitude, rise_evt=1.
REQ-019 Toggle k (k=1..N) occurs at cycle 1+(k-1)*HP; odd k drive amplitude with rise_evt, even k drive 0.0 with fall_evt.
REQ-020 Cycle 1+N*HP: state FINISH, a_out=0.0, busy=0, done=1; fall_evt=1 only when N is odd; next cycle IDLE.
REQ-021 Invalid start (half_period=0 or num_toggles=0): no toggles, busy stays 0, done pulses in cycle 1, a_out stays 0.0.
REQ-022 start while busy=1 or in FINISH is ignored; no queuing.
REQ-023 abort=1 while in RUN: next cycle a_out=0.0, busy=0, IDLE; done not asserted; fall_evt=1 if a_out was at or moving toward amplitude.
REQ-024 abort in IDLE has no effect; abort and start together in IDLE: abort wins, start discarded.
REQ-025 Hold counter counts 0..HP-1 and wraps at each toggle; the toggle counter saturates at N; no overflow at HP_W or CNT_W maxima.
REQ-026 rise_evt and fall_evt are never asserted together.

Reset
REQ-027 rst_n=0 immediately forces a_out=0.0, rise_evt=0, fall_evt=0, busy=0, done=0, state IDLE, all counters and latched values 0.
REQ-028 Reset mid-burst discards the burst without a done pulse; the first start is accepted on the first clock edge after rst_n rises.

Configuration
REQ-029 Macro SQWAVE_SLEW_EN defined: each transition ramps linearly by amplitude/SLEW_STEPS per cycle, starting in the toggle cycle and reaching its target at toggle cycle + SLEW_STEPS-1.
REQ-030 With SQWAVE_SLEW_EN, a start with half_period<SLEW_STEPS is invalid and handled per REQ-021.
REQ-031 Macro undefined: transitions are instantaneous and SLEW_STEPS is unused.

Verification
REQ-032 HP=10, N=20, amp=1.0: 10 rise_evt and 10 fall_evt 10 cycles apart; done at cycle 201; a_out=0.0 after.
REQ-033 HP=2, N=3, amp=0.5: a_out=0.5 in cycles 1-2, 0.0 in 3-4, 0.5 in 5-6; cycle 7 a_out=0.0, fall_evt=1, done=1.
REQ-034 HP=4, N=8, amp=-2.0, abort at cycle 6: a_out=0.0 at cycle 7, busy=0, no done; a new start at cycle 9 is accepted.
REQ-035 rst_n low at cycle 5 of an HP=3, N=5 burst: outputs are 0 without waiting for a clock edge; no done.
REQ-036 start with num_toggles=0, and start while busy: first gives done in cycle 1 with no events; second is ignored.
REQ-037 SQWAVE_SLEW_EN, SLEW_STEPS=4, HP=8, amp=1.0: a_out=0.25, 0.5, 0.75, 1.0 in cycles 1-4; HP=3 start is treated as invalid.
